// File: rtl/dbus_responder_pkg.sv
// rtl/dbus_responder_pkg.sv - shared data-bus types, size encodings and FSM state codes
package dbus_responder_pkg;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2
    } msize_t;

    typedef struct packed {
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic logic is_misaligned(input msize_t size, input logic [1:0] addr_lo);
        return ((size == MSIZE2) && addr_lo[0]) || ((size == MSIZE4) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/dbus_responder_ram_be.sv
// rtl/dbus_responder_ram_be.sv - 1R1W byte-enabled word RAM, read-before-write, one access per clock
module ram_be #(
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  en_i,
    input  logic [DEPTH_LOG2-1:0] idx_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rdata_q;

    // Array kept free of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rdata_q <= '0;
        end else if (en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_responder.sv
// rtl/dbus_responder.sv - data-bus slave: one request at a time, byte-strobed RAM access, fixed latency
module dbus_responder
    import dbus_responder_pkg::*;
#(
    parameter int LATENCY    = 2,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        dreq_valid,
    input  logic [31:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [3:0]  dreq_strobe,
    input  logic [31:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [31:0] dresp_data,
    output logic        misalign_err
);

    dbus_req_t  req_in;
    dbus_resp_t resp;

    logic [1:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic [3:0]            strobe_q, strobe_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  ok_q, ok_d;
    logic                  mis_q, mis_d;
    logic                  wr_q, wr_d;

    logic                  enter_resp;
    logic [DEPTH_LOG2-1:0] ram_idx;
    logic [3:0]            ram_be_sel;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic                  unused_addr_hi;

    assign req_in = '{addr: dreq_addr, size: msize_t'(dreq_size), strobe: dreq_strobe, data: dreq_data};
    assign unused_addr_hi = ^req_in.addr[31:DEPTH_LOG2+2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        strobe_d   = strobe_q;
        wdata_d    = wdata_q;
        mis_d      = mis_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dreq_valid) begin
                    idx_d    = req_in.addr[DEPTH_LOG2+1:2];
                    strobe_d = req_in.strobe;
                    wdata_d  = req_in.data;
                    cnt_d    = 4'(LATENCY - 1);
                    mis_d    = mis_q | is_misaligned(req_in.size, req_in.addr[1:0]);
                    if (LATENCY == 1) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the access happens on the acceptance edge, so take fields straight from the bus.
    assign ram_idx    = (state_q == ST_IDLE) ? req_in.addr[DEPTH_LOG2+1:2] : idx_q;
    assign ram_be_sel = (state_q == ST_IDLE) ? req_in.strobe : strobe_q;
    assign ram_wdata  = (state_q == ST_IDLE) ? req_in.data : wdata_q;

    assign ok_d = enter_resp;
    assign wr_d = enter_resp ? (ram_be_sel != 4'b0000) : wr_q;

    ram_be #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (enter_resp && resetn),
        .idx_i   (ram_idx),
        .be_i    (ram_be_sel),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            ok_q     <= 1'b0;
            mis_q    <= 1'b0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            ok_q     <= ok_d;
            mis_q    <= mis_d;
            wr_q     <= wr_d;
        end
    end

    assign resp = '{addr_ok: ok_q, data_ok: ok_q, data: (wr_q ? 32'h0 : ram_rdata)};

    assign dresp_addr_ok = resp.addr_ok;
    assign dresp_data_ok = resp.data_ok;
    assign dresp_data    = resp.data;
    assign misalign_err  = mis_q;

endmodule

// File: tb/tb_dbus_responder.sv
// tb/tb_dbus_responder.sv - scoreboard bench: LATENCY=2 instance for directed tests, LATENCY=1 for back-to-back
module tb_dbus_responder;
    import dbus_responder_pkg::*;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [31:0] a_addr = '0, b_addr = '0, a_wdata = '0, b_wdata = '0;
    logic [2:0]  a_size = '0, b_size = '0;
    logic [3:0]  a_strb = '0, b_strb = '0;
    logic        a_aok, a_dok, a_mis, b_aok, b_dok, b_mis;
    logic [31:0] a_data, b_data;

    dbus_responder #(.LATENCY(LAT_A), .DEPTH_LOG2(12)) dut_a (
        .clk(clk), .resetn(resetn), .dreq_valid(a_valid), .dreq_addr(a_addr),
        .dreq_size(a_size), .dreq_strobe(a_strb), .dreq_data(a_wdata),
        .dresp_addr_ok(a_aok), .dresp_data_ok(a_dok), .dresp_data(a_data), .misalign_err(a_mis)
    );

    dbus_responder #(.LATENCY(LAT_B), .DEPTH_LOG2(12)) dut_b (
        .clk(clk), .resetn(resetn), .dreq_valid(b_valid), .dreq_addr(b_addr),
        .dreq_size(b_size), .dreq_strobe(b_strb), .dreq_data(b_wdata),
        .dresp_addr_ok(b_aok), .dresp_data_ok(b_dok), .dresp_data(b_data), .misalign_err(b_mis)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;
    logic mis_a = 1'b0;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (a_dok) begin
            if (qa.size() == 0) chk("a_unexpected_data_ok", {31'b0, a_dok}, 32'd0);
            else begin
                ea = qa.pop_front();
                chk("a_resp_data", a_data, ea.data);
                chk("a_resp_cycle", cyc, ea.due);
                chk("a_addr_ok", {31'b0, a_aok}, 32'd1);
            end
        end else if (qa.size() > 0 && cyc > qa[0].due) begin
            chk("a_missing_data_ok", {31'b0, a_dok}, 32'd1);
            void'(qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (b_dok) begin
            if (qb.size() == 0) chk("b_unexpected_data_ok", {31'b0, b_dok}, 32'd0);
            else begin
                eb = qb.pop_front();
                chk("b_resp_data", b_data, eb.data);
                chk("b_resp_cycle", cyc, eb.due);
                chk("b_addr_ok", {31'b0, b_aok}, 32'd1);
            end
        end else if (qb.size() > 0 && cyc > qb[0].due) begin
            chk("b_missing_data_ok", {31'b0, b_dok}, 32'd1);
            void'(qb.pop_front());
        end
    end

    function automatic logic exp_mis(input logic [2:0] size, input logic [31:0] addr);
        return (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after an edge with dut_a idle.
    task automatic req_a(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] strb,
                         input logic [31:0] wd, input logic [31:0] exp);
        a_valid = 1'b1; a_addr = addr; a_size = size; a_strb = strb; a_wdata = wd;
        qa.push_back('{due: cyc + LAT_A, data: exp});
        if (exp_mis(size, addr)) mis_a = 1'b1;
        step();
        chk("a_misalign_err", {31'b0, a_mis}, {31'b0, mis_a});
        for (int i = 0; i < 40 && !a_dok; i++) step();
        if (!a_dok) chk("a_timeout", {31'b0, a_dok}, 32'd1);
        a_valid = 1'b0;
        step();
    endtask

    logic [31:0] vb_addr [4] = '{32'h10, 32'h14, 32'h10, 32'h14};
    logic [3:0]  vb_strb [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
    logic [31:0] vb_data [4] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0, 32'h0};
    logic [31:0] vb_exp  [4] = '{32'h0, 32'h0, 32'hA1A1A1A1, 32'hB2B2B2B2};

    initial begin
        int acc;
        resetn = 1'b0;
        step(); step();
        chk("rst_addr_ok", {31'b0, a_aok}, 32'd0);
        chk("rst_data_ok", {31'b0, a_dok}, 32'd0);
        chk("rst_data", a_data, 32'd0);
        chk("rst_misalign", {31'b0, a_mis}, 32'd0);
        resetn = 1'b1;
        step();

        req_a(32'h100, MSIZE4, 4'hF, 32'hDEADBEEF, 32'h0);
        req_a(32'h100, MSIZE4, 4'h0, 32'h0, 32'hDEADBEEF);

        req_a(32'h200, MSIZE4, 4'hF, 32'h11223344, 32'h0);
        req_a(32'h202, MSIZE1, 4'b0100, 32'h00AA0000, 32'h0);
        req_a(32'h200, MSIZE4, 4'h0, 32'h0, 32'h11AA3344);
        req_a(32'h200, MSIZE2, 4'b0011, 32'h00005566, 32'h0);
        req_a(32'h200, MSIZE4, 4'h0, 32'h0, 32'h11AA5566);

        req_a(32'h4000, MSIZE4, 4'hF, 32'hCAFEF00D, 32'h0);
        req_a(32'h0000, MSIZE4, 4'h0, 32'h0, 32'hCAFEF00D);

        req_a(32'h102, MSIZE4, 4'h0, 32'h0, 32'hDEADBEEF);
        req_a(32'h300, MSIZE4, 4'hF, 32'h12345678, 32'h0);
        chk("misalign_sticky", {31'b0, a_mis}, 32'd1);

        // Write accepted, then reset lands on the edge that would have committed it.
        a_valid = 1'b1; a_addr = 32'h300; a_size = MSIZE4; a_strb = 4'hF; a_wdata = 32'hBAD0BAD0;
        step();
        resetn = 1'b0; a_valid = 1'b0;
        step();
        resetn = 1'b1; mis_a = 1'b0;
        chk("rst_busy_data_ok", {31'b0, a_dok}, 32'd0);
        chk("rst_busy_misalign", {31'b0, a_mis}, 32'd0);
        chk("rst_busy_data", a_data, 32'd0);
        step(); step();
        req_a(32'h300, MSIZE4, 4'h0, 32'h0, 32'h12345678);

        // Reset and valid together: the request must not be taken.
        resetn = 1'b0; a_valid = 1'b1; a_addr = 32'h100; a_strb = 4'h0;
        step();
        resetn = 1'b1; a_valid = 1'b0;
        step(); step(); step();
        chk("rst_valid_no_resp", {31'b0, a_dok}, 32'd0);

        // Back-to-back on the LATENCY=1 instance with valid never dropped.
        acc = cyc + 1;
        b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_addr = vb_addr[k]; b_size = MSIZE4; b_strb = vb_strb[k]; b_wdata = vb_data[k];
            qb.push_back('{due: acc + LAT_B - 1, data: vb_exp[k]});
            acc = acc + LAT_B + 1;
            step();
            for (int i = 0; i < 20 && !b_dok; i++) step();
            if (!b_dok) chk("b_timeout", {31'b0, b_dok}, 32'd1);
        end
        b_valid = 1'b0;
        step(); step(); step(); step();

        chk("a_queue_drained", qa.size(), 32'd0);
        chk("b_queue_drained", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
